mem_copy_initiator: RTL

//  Bus initiator for the lab8 memory bus (mem_cmd/mem_addr/out/read_data): copies LEN consecutive 16-bit

---
 rtl/lab8_bus_pkg.sv | 21 ++
 rtl/copy_ptr_unit.sv | 54 +++++
 rtl/mem_copy_initiator.sv | 117 +++++++++++
 3 files changed

// File: rtl/lab8_bus_pkg.sv
// Shared definitions for the lab8 memory bus: command codes, I/O map and
// the copy engine state encoding.
package lab8_bus_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  localparam logic [8:0] IO_LED_ADDR = 9'h100;
  localparam logic [8:0] IO_SW_ADDR  = 9'h140;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_WR      = 3'd4,
    S_DONE    = 3'd5
  } copy_state_e;

endpackage

// File: rtl/copy_ptr_unit.sv
// Source/destination word pointers and remaining-word counter for the copy
// engine. Pointers wrap modulo 2**ADDR_W.
module copy_ptr_unit #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] src_ptr_o,
  output logic [ADDR_W-1:0] dst_ptr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      rem_d = len_i;
    end else if (advance_i) begin
      src_d = src_q + 1'b1;
      dst_d = dst_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign src_ptr_o = src_q;
  assign dst_ptr_o = dst_q;
  assign last_o    = (rem_q == LEN_W'(1));

endmodule

// File: rtl/mem_copy_initiator.sv
// Bus-initiator copy engine: moves LEN words from SRC to DST over the lab8
// memory bus with read/read/write cycles, yielding whenever the grant drops.
module mem_copy_initiator
  import lab8_bus_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              done
);

  copy_state_e state_q, state_d;

  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              last_word;
  logic              load, advance, capture;
  logic              drive_rd, drive_wr;

  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] out_q;

  copy_ptr_unit #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .advance_i (advance),
    .src_i     (src_addr),
    .dst_i     (dst_addr),
    .len_i     (len),
    .src_ptr_o (src_ptr),
    .dst_ptr_o (dst_ptr),
    .last_o    (last_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A lost grant in any bus phase falls back to REQ, so the element restarts
  // from its read with the pointers untouched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (len != '0) ? S_REQ : S_DONE;
      S_REQ:     if (bus_gnt) state_d = S_RD_ADDR;
      S_RD_ADDR: state_d = bus_gnt ? S_RD_DATA : S_REQ;
      S_RD_DATA: state_d = bus_gnt ? S_WR : S_REQ;
      S_WR: begin
        if (!bus_gnt)      state_d = S_REQ;
        else if (last_word) state_d = S_DONE;
        else               state_d = S_RD_ADDR;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drive_rd = bus_gnt && ((state_q == S_RD_ADDR) || (state_q == S_RD_DATA));
    drive_wr = bus_gnt && (state_q == S_WR);
    load     = (state_q == S_IDLE) && start && (len != '0);
    advance  = drive_wr;
    capture  = bus_gnt && (state_q == S_RD_DATA);

    bus_req  = (state_q == S_REQ) || (state_q == S_RD_ADDR) ||
               (state_q == S_RD_DATA) || (state_q == S_WR);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);

    if (drive_wr)      mem_cmd = MWRITE;
    else if (drive_rd) mem_cmd = MREAD;
    else               mem_cmd = MNONE;

    if (drive_wr)      mem_addr = dst_ptr;
    else if (drive_rd) mem_addr = src_ptr;
    else               mem_addr = addr_q;

    out = drive_wr ? data_q : out_q;
  end

  // Idle-cycle hold registers keep mem_addr/out stable while mem_cmd is none.
  always_comb begin
    data_d = capture ? read_data : data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      addr_q <= '0;
      out_q  <= '0;
    end else begin
      data_q <= data_d;
      addr_q <= mem_addr;
      out_q  <= out;
    end
  end

endmodule
